// File: rtl/ddr3_test_pkg.sv
// Shared types and constants for the DDR3 example-design traffic checkers.
package ddr3_test_pkg;

    // Read-checker control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } rd_state_e;

    localparam logic [2:0]  AXI_SIZE_64    = 3'b011;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [63:0] PATTERN_01     = 64'h0000_ffff_0000_ffff;
    localparam int          LANES          = 4;

    // One 16-bit lane of the address pattern; the byte add wraps at 8 bits.
    function automatic logic [15:0] lane_word(input logic [7:0] base, input int k);
        logic [7:0] b;
        b = base + 8'(k);
        return {8'h00, b};
    endfunction

endpackage

// File: rtl/ddr3_pattern_gen64.sv
// Combinational expected-data generator for one 64-bit beat, shared by the
// write and read sides of the traffic generator.
module ddr3_pattern_gen64
    import ddr3_test_pkg::*;
(
    input  logic [7:0]  addr_lsb_i,
    input  logic        pattern_01_i,
    output logic [63:0] exp_data_o
);

    // Build either the fixed 01 pattern or the per-lane address pattern.
    always_comb begin
        exp_data_o = PATTERN_01;
        if (!pattern_01_i) begin
            for (int k = 0; k < LANES; k++) begin
                exp_data_o[16*k +: 16] = lane_word(addr_lsb_i, k);
            end
        end
    end

endmodule

// File: rtl/ddr3_rd_check_64bit.sv
// AXI read-back checker for the DDR3 traffic generator: one AR per burst,
// every R beat compared with the regenerated write pattern.
// Optional macro RD_CHECK_ERR_CAPTURE_EN adds first-error capture outputs
// err_addr / err_exp / err_act.
module ddr3_rd_check_64bit
    import ddr3_test_pkg::*;
#(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int ERR_CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       read_en,
    input  logic [CTRL_ADDR_WIDTH-1:0] rd_addr,
    input  logic [3:0]                 rd_id,
    input  logic [3:0]                 rd_len,
    input  logic                       data_pattern_01,
    input  logic                       err_clr,
    output logic                       busy,
    output logic                       read_done_p,
    output logic [31:0]                axi_araddr,
    output logic [7:0]                 axi_arid,
    output logic [7:0]                 axi_arlen,
    output logic [2:0]                 axi_arsize,
    output logic [1:0]                 axi_arburst,
    output logic                       axi_arvalid,
    input  logic                       axi_arready,
    input  logic [63:0]                axi_rdata,
    input  logic [7:0]                 axi_rid,
    input  logic [1:0]                 axi_rresp,
    input  logic                       axi_rlast,
    input  logic                       axi_rvalid,
    output logic                       axi_rready,
    output logic                       err_flag,
    output logic [ERR_CNT_W-1:0]       err_cnt,
    output logic                       len_err
`ifdef RD_CHECK_ERR_CAPTURE_EN
    ,
    output logic [31:0]                err_addr,
    output logic [63:0]                err_exp,
    output logic [63:0]                err_act
`endif
);

    rd_state_e            state_q, state_d;
    logic [31:0]          araddr_q, araddr_d;
    logic [7:0]           arid_q, arid_d;
    logic [7:0]           arlen_q, arlen_d;
    logic [31:0]          beat_addr_q, beat_addr_d;
    logic [7:0]           beat_cnt_q, beat_cnt_d;
    logic                 pat01_q, pat01_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 err_flag_q, err_flag_d;
    logic                 len_err_q, len_err_d;

    logic        beat_fire;
    logic        last_exp;
    logic        len_viol;
    logic        beat_bad;
    logic [63:0] exp_data;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    ddr3_pattern_gen64 u_pat (
        .addr_lsb_i   (beat_addr_q[7:0]),
        .pattern_01_i (pat01_q),
        .exp_data_o   (exp_data)
    );

    assign beat_fire = (state_q == DATA) && axi_rvalid;
    assign last_exp  = (beat_cnt_q == arlen_q);
    assign len_viol  = beat_fire && (axi_rlast != last_exp);
    assign beat_bad  = beat_fire && ((axi_rdata != exp_data) || (axi_rresp != 2'b00) ||
                                     (axi_rid != arid_q) || len_viol);

    // Next-state and request latching for the burst sequencer.
    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        arid_d      = arid_q;
        arlen_d     = arlen_q;
        beat_addr_d = beat_addr_q;
        beat_cnt_d  = beat_cnt_q;
        pat01_d     = pat01_q;
        case (state_q)
            IDLE: begin
                if (read_en) begin
                    araddr_d    = 32'({rd_addr, 1'b0});
                    arid_d      = {4'h0, rd_id};
                    arlen_d     = {4'h0, rd_len};
                    beat_addr_d = {1'b0, araddr_d[31:1]};
                    beat_cnt_d  = '0;
                    pat01_d     = data_pattern_01;
                    state_d     = AR;
                end
            end
            AR: begin
                if (axi_arready) state_d = DATA;
            end
            DATA: begin
                if (beat_fire) begin
                    beat_addr_d = beat_addr_q + 32'd4;
                    beat_cnt_d  = beat_cnt_q + 8'd1;
                    // A missing rlast still closes the burst after beat arlen.
                    if (axi_rlast || last_exp) state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sticky error status; a same-cycle clear is applied before the new error.
    always_comb begin
        err_cnt_d  = err_clr ? '0 : err_cnt_q;
        err_flag_d = err_clr ? 1'b0 : err_flag_q;
        len_err_d  = err_clr ? 1'b0 : len_err_q;
        if (beat_bad) begin
            err_cnt_d  = sat_inc(err_cnt_d);
            err_flag_d = 1'b1;
        end
        if (len_viol) len_err_d = 1'b1;
    end

    // State and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            araddr_q    <= '0;
            arid_q      <= '0;
            arlen_q     <= '0;
            beat_addr_q <= '0;
            beat_cnt_q  <= '0;
            pat01_q     <= 1'b0;
            err_cnt_q   <= '0;
            err_flag_q  <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            arid_q      <= arid_d;
            arlen_q     <= arlen_d;
            beat_addr_q <= beat_addr_d;
            beat_cnt_q  <= beat_cnt_d;
            pat01_q     <= pat01_d;
            err_cnt_q   <= err_cnt_d;
            err_flag_q  <= err_flag_d;
            len_err_q   <= len_err_d;
        end
    end

`ifdef RD_CHECK_ERR_CAPTURE_EN
    logic        cap_vld_q, cap_vld_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [63:0] err_exp_q, err_exp_d;
    logic [63:0] err_act_q, err_act_d;

    // Capture only the first bad beat since the last reset or clear.
    always_comb begin
        cap_vld_d  = err_clr ? 1'b0 : cap_vld_q;
        err_addr_d = err_clr ? '0 : err_addr_q;
        err_exp_d  = err_clr ? '0 : err_exp_q;
        err_act_d  = err_clr ? '0 : err_act_q;
        if (beat_bad && !cap_vld_d) begin
            cap_vld_d  = 1'b1;
            err_addr_d = beat_addr_q;
            err_exp_d  = exp_data;
            err_act_d  = axi_rdata;
        end
    end

    // First-error capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld_q  <= 1'b0;
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_act_q  <= '0;
        end else begin
            cap_vld_q  <= cap_vld_d;
            err_addr_q <= err_addr_d;
            err_exp_q  <= err_exp_d;
            err_act_q  <= err_act_d;
        end
    end

    assign err_addr = err_addr_q;
    assign err_exp  = err_exp_q;
    assign err_act  = err_act_q;
`else
    logic unused_beat_hi;
    assign unused_beat_hi = ^beat_addr_q[31:8];
`endif

    assign busy        = (state_q != IDLE);
    assign axi_arvalid = (state_q == AR);
    assign axi_rready  = (state_q == DATA);
    assign read_done_p = (state_q == DONE);
    assign axi_araddr  = araddr_q;
    assign axi_arid    = arid_q;
    assign axi_arlen   = arlen_q;
    assign axi_arsize  = AXI_SIZE_64;
    assign axi_arburst = AXI_BURST_INCR;
    assign err_cnt     = err_cnt_q;
    assign err_flag    = err_flag_q;
    assign len_err     = len_err_q;

endmodule

// File: doc/ddr3_rd_check_64bit.md
# ddr3_rd_check_64bit

Read-back checker for the DDR3 example-design traffic generator. It sits on the AXI read channel beside the 64-bit write controller. For each requested burst it issues one AR request and consumes the R beats. It regenerates the deterministic write pattern for every beat from the burst address, compares it with the returned data, and reports pass/fail status to the test top.

## Interface
- `CTRL_ADDR_WIDTH`, 28: width of `rd_addr` (controller half-word address).
- `ERR_CNT_W`, 16: width of the saturating error counter.
- `clk` in 1: controller clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `read_en` in 1: start request, sampled only in IDLE.
- `rd_addr` in CTRL_ADDR_WIDTH: burst start address.
- `rd_id` in 4: AXI ID for the burst.
- `rd_len` in 4: beats minus one.
- `data_pattern_01` in 1: expect the fixed 01 pattern instead of the address pattern.
- `err_clr` in 1: clears `err_flag`, `err_cnt`, `len_err` (and capture registers when present).
- `busy` out 1: high whenever state ≠ IDLE.
- `read_done_p` out 1: one-cycle pulse at the end of each burst.
- `axi_araddr` out 32; `axi_arid` out 8; `axi_arlen` out 8.
- `axi_arsize` out 3: constant 3'b011.
- `axi_arburst` out 2: constant 2'b01.
- `axi_arvalid` out 1; `axi_arready` in 1.
- `axi_rdata` in 64; `axi_rid` in 8; `axi_rresp` in 2; `axi_rlast` in 1; `axi_rvalid` in 1; `axi_rready` out 1.
- `err_flag` out 1: sticky; set by any beat error.
- `err_cnt` out ERR_CNT_W: saturating count of erroneous beats.
- `len_err` out 1: sticky; set on burst-length mismatch.

## Operation
- Reset values: all outputs are 0 except the constants `axi_arsize` = 3'b011 and `axi_arburst` = 2'b01. State is IDLE.
- State machine:
  - IDLE: on `read_en`, latch the request and go to AR.
    - `axi_araddr` = {zeros, rd_addr, 1'b0}.
    - `axi_arid` = {4'h0, rd_id}.
    - `axi_arlen` = {4'h0, rd_len}.
    - `beat_addr` (32 bit) = {1'b0, araddr[31:1]}.
    - `beat_cnt` = 0.
  - AR: `axi_arvalid` = 1 and held until `axi_arvalid & axi_arready`. On the handshake, clear `axi_arvalid` and go to DATA.
  - DATA: `axi_rready` = 1. Each `axi_rvalid & axi_rready` beat is checked, then `beat_addr` += 4 and `beat_cnt` += 1.
    - A beat with `axi_rlast`=1 ends the burst: go to DONE.
  - DONE: `read_done_p` = 1 for exactly this cycle, then IDLE. `axi_rready` = 0.
- Expected data per beat:
  - `data_pattern_01`=1: 64'h0000_ffff_0000_ffff.
  - Otherwise: lane k (k = 0..3, lane 0 = bits 15:0) = {8'h00, beat_addr[7:0] + k}. The addition is 8 bits and wraps, so 0xFE + 3 = 0x01.
- A beat is erroneous if any of these hold:
  - `axi_rdata` ≠ expected,
  - `axi_rresp` ≠ 0,
  - `axi_rid` ≠ `axi_arid`,
  - length violation: `axi_rlast` high with `beat_cnt` ≠ arlen, or `axi_rlast` low with `beat_cnt` == arlen.
- Length violation handling:
  - `len_err` sets on either case.
  - On a missing `rlast`, the burst still ends after beat arlen.
  - On an early `rlast`, the burst ends at that beat.
- Each erroneous beat increments `err_cnt` by one; it saturates at all-ones. `err_flag` sets.
- `err_clr` together with an erroneous beat in the same cycle: the clear applies first. Result is `err_cnt` = 1 and `err_flag` = 1.
- `read_en` outside IDLE is ignored.
- `rst` mid-burst: immediate return to IDLE with reset values. Outstanding R beats are not tracked.

## Timing
- `read_en` at cycle 0 → `axi_arvalid` high at cycle 1.
- Earliest beat acceptance is the cycle after the AR handshake.
- Each beat is compared in its handshake cycle. Error registers update at the next edge, so there is 1-cycle latency.
- `read_done_p` comes 1 cycle after the last-beat handshake. The next `read_en` can be accepted the cycle after DONE.
- Minimum burst with len 0: 4 cycles from `read_en` to back in IDLE, given `arready` and `rvalid` are immediately high.
- `axi_rready` is combinational from state only, never from `rvalid`.

## Configuration
- `RD_CHECK_ERR_CAPTURE_EN` defined: adds outputs `err_addr` (32), `err_exp` (64) and `err_act` (64).
  - These capture `beat_addr`, expected data and actual data of the first erroneous beat after reset or `err_clr`.
  - They hold until the next clear.
- Not defined: these ports and registers are absent. All other behaviour is identical.

## Structure
- Shared package `ddr3_test_pkg`:
  - State enum: IDLE/AR/DATA/DONE.
  - Constants: AXI_SIZE_64 = 3'b011, AXI_BURST_INCR = 2'b01, PATTERN_01 = 64'h0000_ffff_0000_ffff.
  - Lane count: 4.
- One sub-module, `ddr3_pattern_gen64`: combinational expected-data generator taking (beat_addr[7:0], data_pattern_01). The write-side generator should reuse it.

## Test plan
- `rd_addr`=0x40, len 3, ideal slave returning the correct pattern:
  - `axi_araddr`=0x80.
  - Beat 0 = 64'h0043_0042_0041_0040.
  - `read_done_p` once.
  - `err_cnt`=0.
- `data_pattern_01`=1, len 15: slave returns 64'h0000_ffff_0000_ffff ×16 → no error. Corrupt beat 5 bit 0 → `err_cnt`=1 and `err_flag`=1.
- Length errors:
  - len 3, slave asserts `rlast` on beat 1 → `len_err`=1, `err_cnt`=1, done after 2 beats.
  - Slave omits `rlast` → `len_err`=1, done after 4 beats.
- `axi_arready` held low 10 cycles → `axi_arvalid` stays high and `axi_araddr` stays stable; no `rready` before the handshake.
- `rresp`=2'b10 on one beat and `rid` mismatch on another → `err_cnt`=2. Then `err_clr` asserted in the same cycle as a bad beat → `err_cnt`=1.
- `rst` asserted mid-DATA → next cycle all outputs are at reset values and `busy`=0. A new burst then completes cleanly.
